rpn_sequencer: RTL and testbench



---
 rtl/rpn_pkg.sv | 41 ++++
 rtl/rpn_alu.sv | 37 +++
 rtl/rpn_sequencer.sv | 149 ++++++++++++++
 tb/tb_rpn_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared opcodes, FSM state encoding, default sizes and the fas16 adder/subtractor.
package rpn_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 8;
    localparam int CNT_W_DEF = 4;

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_DUP  = 3'b110;
    localparam logic [2:0] OP_EMIT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PUSH = 3'd1,
        S_POPA = 3'd2,
        S_OPB  = 3'd3,
        S_DUP  = 3'd4,
        S_EMIT = 3'd5
    } state_t;

    // Ripple full adder/subtractor: x + y, or x - y when sub=1 (two's complement, carry dropped).
    function automatic logic [15:0] fas16(input logic [15:0] x, input logic [15:0] y,
                                          input logic sub);
        logic [15:0] yy;
        logic [15:0] s;
        logic        c;
        yy = y ^ {16{sub}};
        c  = sub;
        for (int i = 0; i < 16; i++) begin
            s[i] = x[i] ^ yy[i] ^ c;
            c    = (x[i] & yy[i]) | (c & (x[i] ^ yy[i]));
        end
        return s;
    endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational binary operator: y = b op a, b being the deeper stack operand.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] y_o
);

    logic [WIDTH-1:0] add_y;
    logic [WIDTH-1:0] sub_y;

    if (WIDTH == 16) begin : g_fas
        assign add_y = fas16(b_i, a_i, 1'b0);
        assign sub_y = fas16(b_i, a_i, 1'b1);
    end else begin : g_gen
        assign add_y = b_i + a_i;
        assign sub_y = b_i - a_i;
    end

    // Operator select; non-arithmetic opcodes never reach the ALU and yield zero.
    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = add_y;
            OP_SUB:  y_o = sub_y;
            OP_AND:  y_o = b_i & a_i;
            OP_OR:   y_o = b_i | a_i;
            OP_XOR:  y_o = b_i ^ a_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/rpn_sequencer.sv
// RPN token sequencer driving an external push/pop stack, with depth tracking and sticky error.
//
//   state  | meaning
//   IDLE   | ready for a token; checks depth before starting an operation
//   PUSH   | write registered operand onto the stack
//   POPA   | capture top (A) and pop it
//   OPB    | replace new top (B) with B op A
//   DUP    | push a copy of the top
//   EMIT   | offer top on result port, pop on handshake
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [2:0]       tok_op,
    input  logic [WIDTH-1:0] tok_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_wdata,
    input  logic [WIDTH-1:0] stk_top,
    output logic [CNT_W-1:0] depth,
    output logic             err,
    input  logic             err_clr
);

    state_t           state_q;
    logic [CNT_W-1:0] depth_q;
    logic             err_q;
    logic             rdy_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] a_q;
    logic [2:0]       op_q;

    logic             accept;
    logic             tok_bad;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] alu_y;

    assign full   = (depth_q == CNT_W'(DEPTH));
    assign empty  = (depth_q == '0);
    // rdy_q keeps tok_ready low while reset is held and rises on the first edge after release.
    assign tok_ready = rdy_q && (state_q == S_IDLE);
    assign accept    = tok_valid && tok_ready;

    // Depth check for the offered token; a failing token is consumed and flagged.
    always_comb begin
        tok_bad = 1'b0;
        case (tok_op)
            OP_PUSH: tok_bad = full;
            OP_DUP:  tok_bad = empty || full;
            OP_EMIT: tok_bad = empty;
            default: tok_bad = (depth_q < CNT_W'(2));
        endcase
    end

    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .a_i  (a_q),
        .b_i  (stk_top),
        .op_i (op_q),
        .y_o  (alu_y)
    );

    // Sequencer FSM with depth counter and sticky error; err_clr wins over a same-cycle token.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            depth_q <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            opnd_q  <= '0;
            a_q     <= '0;
            op_q    <= OP_PUSH;
        end else begin
            rdy_q <= 1'b1;
            if (err_clr) begin
                err_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept && !err_clr && !err_q) begin
                        if (tok_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            case (tok_op)
                                OP_PUSH: begin
                                    opnd_q  <= tok_data;
                                    state_q <= S_PUSH;
                                end
                                OP_DUP:  state_q <= S_DUP;
                                OP_EMIT: state_q <= S_EMIT;
                                default: begin
                                    op_q    <= tok_op;
                                    state_q <= S_POPA;
                                end
                            endcase
                        end
                    end
                end
                S_PUSH, S_DUP: begin
                    depth_q <= depth_q + CNT_W'(1);
                    state_q <= S_IDLE;
                end
                S_POPA: begin
                    a_q     <= stk_top;
                    depth_q <= depth_q - CNT_W'(1);
                    state_q <= S_OPB;
                end
                S_OPB: state_q <= S_IDLE;
                S_EMIT: begin
                    if (res_ready) begin
                        depth_q <= depth_q - CNT_W'(1);
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stk_push  = (state_q == S_PUSH) || (state_q == S_OPB) || (state_q == S_DUP);
    assign stk_pop   = (state_q == S_POPA) || (state_q == S_OPB) ||
                       ((state_q == S_EMIT) && res_ready);
    assign res_valid = (state_q == S_EMIT);
    assign res_data  = res_valid ? stk_top : '0;
    assign depth     = depth_q;
    assign err       = err_q;

    // Write data follows the state: operand, ALU result or a copy of the top.
    always_comb begin
        stk_wdata = '0;
        case (state_q)
            S_PUSH:  stk_wdata = opnd_q;
            S_OPB:   stk_wdata = alu_y;
            S_DUP:   stk_wdata = stk_top;
            default: stk_wdata = '0;
        endcase
    end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer: behavioural stack, token-level RPN model and directed vectors.
module tb_rpn_sequencer;

    logic        clk;
    logic        reset;
    logic        tok_valid;
    logic        tok_ready;
    logic [2:0]  tok_op;
    logic [15:0] tok_data;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        stk_push;
    logic        stk_pop;
    logic [15:0] stk_wdata;
    logic [15:0] stk_top;
    logic [3:0]  depth;
    logic        err;
    logic        err_clr;

    int n_checks = 0;
    int n_err    = 0;
    int pop_cnt  = 0;

    rpn_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_op    (tok_op),
        .tok_data  (tok_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_wdata (stk_wdata),
        .stk_top   (stk_top),
        .depth     (depth),
        .err       (err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached stack: 8 x 16, shared reset, push+pop together replaces the top.
    logic [15:0] smem [0:7];
    logic [3:0]  sp;
    assign stk_top = (sp == 4'd0) ? 16'h0000 : smem[sp[2:0] - 3'd1];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp <= 4'd0;
        end else if (stk_push && stk_pop) begin
            if (sp != 4'd0) smem[sp[2:0] - 3'd1] <= stk_wdata;
        end else if (stk_push) begin
            if (sp < 4'd8) begin
                smem[sp[2:0]] <= stk_wdata;
                sp <= sp + 4'd1;
            end
        end else if (stk_pop) begin
            if (sp != 4'd0) sp <= sp - 4'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Token-level model: stack contents, error flag and queue of values to be emitted.
    logic [15:0] m_stk [$];
    logic [15:0] exp_q [$];
    logic        m_err = 1'b0;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_data = 16'h0;

    always @(negedge clk) begin
        logic [15:0] a, b, r;
        if (!reset) begin
            m_stk.delete();
            exp_q.delete();
            m_err     = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (stk_pop) pop_cnt++;
            check("depth_range", {31'd0, depth <= 4'd8}, 32'd1);
            if (stk_push && stk_pop) check("replace_nonempty", {31'd0, sp != 4'd0}, 32'd1);
            if (tok_ready) begin
                check("idle_no_ctl", {29'd0, stk_push, stk_pop, res_valid}, 32'd0);
                check("idle_depth", {28'd0, depth}, m_stk.size());
                check("idle_err", {31'd0, err}, {31'd0, m_err});
            end
            if (prev_hold) check("res_hold", {15'd0, res_valid, res_data}, {15'd0, 1'b1, prev_data});
            prev_hold = res_valid && !res_ready;
            prev_data = res_data;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL res_unexpected: got 0x%0h, expected no result", res_data);
                end else begin
                    check("res_data", {16'd0, res_data}, {16'd0, exp_q.pop_front()});
                end
            end
            // Apply the token that the coming edge accepts.
            if (err_clr) begin
                m_err = 1'b0;
            end else if (tok_valid && tok_ready && !m_err) begin
                case (tok_op)
                    3'b000: if (m_stk.size() == 8) m_err = 1'b1;
                            else m_stk.push_back(tok_data);
                    3'b110: if (m_stk.size() == 0 || m_stk.size() == 8) m_err = 1'b1;
                            else m_stk.push_back(m_stk[$]);
                    3'b111: if (m_stk.size() == 0) m_err = 1'b1;
                            else exp_q.push_back(m_stk.pop_back());
                    default: begin
                        if (m_stk.size() < 2) begin
                            m_err = 1'b1;
                        end else begin
                            a = m_stk.pop_back();
                            b = m_stk.pop_back();
                            case (tok_op)
                                3'b001:  r = b + a;
                                3'b010:  r = b - a;
                                3'b011:  r = b & a;
                                3'b100:  r = b | a;
                                default: r = b ^ a;
                            endcase
                            m_stk.push_back(r);
                        end
                    end
                endcase
            end
        end
    end

    // Offer a token until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [15:0] d);
        bit ok = 1'b0;
        tok_valid = 1'b1;
        tok_op    = op;
        tok_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tok_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: tok_ready stayed 0 for op %0d", op);
        end
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tok_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL idle_timeout: tok_ready stayed 0");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string name, input logic [15:0] val);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                ok = 1'b1;
                check(name, {16'd0, res_data}, {16'd0, val});
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: no result handshake, expected 0x%0h", name, val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic emit_expect(input string name, input logic [15:0] val);
        send(3'b111, 16'h0);
        wait_result(name, val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        reset     = 1'b1;
        tok_valid = 1'b0;
        tok_op    = 3'b000;
        tok_data  = 16'h0;
        res_ready = 1'b1;
        err_clr   = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_tok_ready", {31'd0, tok_ready}, 32'd0);
        check("rst_depth", {28'd0, depth}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ctl", {28'd0, stk_push, stk_pop, res_valid, |res_data}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rel_tok_ready", {31'd0, tok_ready}, 32'd1);

        // 5 - 3
        send(3'b000, 16'd5);
        send(3'b000, 16'd3);
        send(3'b010, 16'h0);
        emit_expect("sub_5_3", 16'h0002);
        wait_idle();
        check("sub_depth", {28'd0, depth}, 32'd0);
        check("sub_err", {31'd0, err}, 32'd0);

        // Wrapping add and borrowing sub
        send(3'b000, 16'hFFFF);
        send(3'b000, 16'h0002);
        send(3'b001, 16'h0);
        emit_expect("add_wrap", 16'h0001);
        send(3'b000, 16'h0000);
        send(3'b000, 16'h0001);
        send(3'b010, 16'h0);
        emit_expect("sub_wrap", 16'hFFFF);

        // Overflow on the ninth push
        for (int i = 1; i <= 9; i++) send(3'b000, 16'(i));
        check("ovf_err", {31'd0, err}, 32'd1);
        check("ovf_depth", {28'd0, depth}, 32'd8);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        check("ovf_clr", {31'd0, err}, 32'd0);
        for (int i = 0; i < 8; i++) emit_expect("emit_seq", 16'(8 - i));
        wait_idle();
        check("seq_depth", {28'd0, depth}, 32'd0);

        // Fresh reset, underflowing ADD, err_clr beating a PUSH
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        pc = pop_cnt;
        send(3'b001, 16'h0);
        check("udf_err", {31'd0, err}, 32'd1);
        check("udf_depth", {28'd0, depth}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("udf_no_pop", pop_cnt, pc);
        err_clr = 1'b1;
        send(3'b000, 16'd7);
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("clr_err", {31'd0, err}, 32'd0);
        check("clr_depth", {28'd0, depth}, 32'd0);

        // DUP + XOR, then a stalled EMIT
        send(3'b000, 16'h00F0);
        send(3'b110, 16'h0);
        send(3'b101, 16'h0);
        res_ready = 1'b0;
        send(3'b111, 16'h0);
        pc = pop_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, res_valid}, 32'd1);
            check("stall_data", {16'd0, res_data}, 32'd0);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_result("stall_res", 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("stall_one_pop", pop_cnt, pc + 1);
        check("stall_depth", {28'd0, depth}, 32'd0);

        // Reset during the replace cycle of AND
        send(3'b000, 16'd4);
        send(3'b000, 16'd6);
        send(3'b011, 16'h0);
        @(posedge clk);
        #1;
        check("opb_ctl", {30'd0, stk_push, stk_pop}, 32'd3);
        reset = 1'b0;
        #1;
        check("mid_rst_out", {27'd0, tok_ready, stk_push, stk_pop, res_valid, err}, 32'd0);
        check("mid_rst_depth", {28'd0, depth}, 32'd0);
        check("mid_rst_wdata", {16'd0, stk_wdata}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", {31'd0, tok_ready}, 32'd1);
        check("post_rst_depth", {28'd0, depth}, 32'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
